// File: rtl/mips_trace_defines.sv
// Shared definitions for the MIPS trace transmitter.
//   - MIPS_NOP        : all-zero NOP encoding used by the core
//   - HDR_PREFIX      : 3-bit sync prefix at the top of every header byte
//   - HDR_*_BIT       : header flag bit positions
//   - tx_state_e      : serializer FSM state encodings
//   - trace_rec_t     : one captured trace record; field offsets are fixed
//                       by the packed struct (reg_data at bit 0, gap at MSB)
//   - next_field()    : next present field after a given one (IDLE = end)
//   - is_word_field() : field is 4 bytes wide
//   - field_byte()    : byte emitted for a field / byte index
package mips_trace_defines;

   localparam logic [31:0] MIPS_NOP   = 32'h0000_0000;
   localparam logic [2:0]  HDR_PREFIX = 3'b101;

   localparam int unsigned HDR_GAP_BIT = 4;
   localparam int unsigned HDR_NOP_BIT = 3;
   localparam int unsigned HDR_MEM_BIT = 2;
   localparam int unsigned HDR_REG_BIT = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_PC    = 3'd2,
      ST_INSTR = 3'd3,
      ST_MADDR = 3'd4,
      ST_MDATA = 3'd5,
      ST_RADDR = 3'd6,
      ST_RDATA = 3'd7
   } tx_state_e;

   typedef struct packed {
      logic        gap;
      logic        is_nop;
      logic        mem_we;
      logic        reg_we;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_data;
      logic [4:0]  reg_addr;
      logic [31:0] reg_data;
   } trace_rec_t;

   localparam int unsigned REC_W = $bits(trace_rec_t);

   // Returns the field that follows st in a packet, skipping absent ones.
   function automatic tx_state_e next_field(input tx_state_e st, input logic is_nop,
                                            input logic mem_we, input logic reg_we);
      tx_state_e nxt;
      case (st)
         ST_HDR:   nxt = ST_PC;
         ST_PC: begin
            if (!is_nop)     nxt = ST_INSTR;
            else if (mem_we) nxt = ST_MADDR;
            else if (reg_we) nxt = ST_RADDR;
            else             nxt = ST_IDLE;
         end
         ST_INSTR: begin
            if (mem_we)      nxt = ST_MADDR;
            else if (reg_we) nxt = ST_RADDR;
            else             nxt = ST_IDLE;
         end
         ST_MADDR: nxt = ST_MDATA;
         ST_MDATA: begin
            if (reg_we) nxt = ST_RADDR;
            else        nxt = ST_IDLE;
         end
         ST_RADDR: nxt = ST_RDATA;
         default:  nxt = ST_IDLE;
      endcase
      return nxt;
   endfunction

   function automatic logic is_word_field(input tx_state_e st);
      logic w;
      case (st)
         ST_PC, ST_INSTR, ST_MADDR, ST_MDATA, ST_RDATA: w = 1'b1;
         default:                                       w = 1'b0;
      endcase
      return w;
   endfunction

   // Big-endian byte select: idx 0 is the most significant byte of a word.
   function automatic logic [7:0] field_byte(input tx_state_e st, input logic [1:0] idx,
                                             input trace_rec_t rec);
      logic [31:0] word;
      logic [7:0]  b;
      case (st)
         ST_PC:    word = rec.pc;
         ST_INSTR: word = rec.instr;
         ST_MADDR: word = rec.mem_addr;
         ST_MDATA: word = rec.mem_data;
         ST_RDATA: word = rec.reg_data;
         default:  word = 32'h0000_0000;
      endcase
      case (st)
         ST_HDR: begin
            b              = 8'h00;
            b[7:5]         = HDR_PREFIX;
            b[HDR_GAP_BIT] = rec.gap;
            b[HDR_NOP_BIT] = rec.is_nop;
            b[HDR_MEM_BIT] = rec.mem_we;
            b[HDR_REG_BIT] = rec.reg_we;
         end
         ST_RADDR: b = {3'b000, rec.reg_addr};
         default: begin
            case (idx)
               2'd0:    b = word[31:24];
               2'd1:    b = word[23:16];
               2'd2:    b = word[15:8];
               default: b = word[7:0];
            endcase
         end
      endcase
      return b;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace records.
//   clk, rst_n : clock, async active-low reset (clears pointers only)
//   push_i     : write wdata_i; honoured when not full or popping this edge
//   pop_i      : drop the head entry; ignored when empty
//   wdata_i    : entry to write
//   rdata_o    : current head entry (valid when !empty_o)
//   full_o     : FIFO holds DEPTH entries
//   empty_o    : FIFO holds no entries
// Full/empty come from read/write pointers carrying one extra wrap bit.
module trace_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push_s, do_pop_s;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop_s  = pop_i & ~empty_o;
   // When full, the slot being written is the head being popped on this edge.
   assign do_push_s = push_i & (~full_o | do_pop_s);
   assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/mips_trace_tx.sv
// MIPS per-cycle trace transmitter.
//   clk, rst_n        : clock, async active-low reset
//   en                : capture one record per edge while high
//   pc, instr         : traced fetch PC and instruction (instr==0 is NOP)
//   mem_we/addr/data  : memory-stage store
//   reg_we/addr/data  : writeback-stage register write
//   out_data/valid    : byte stream, held stable while out_ready is low
//   out_ready         : consumer accepts the current byte
//   overflow          : sticky, set on the first dropped record
//   drop_count        : saturating count of dropped records
// Records are queued in trace_fifo and serialized as header, pc, optional
// instr, optional mem_addr/mem_data, optional reg_addr/reg_data, big-endian.
module mips_trace_tx
   import mips_trace_defines::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [31:0]      pc,
   input  logic [31:0]      instr,
   input  logic             mem_we,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_data,
   input  logic             reg_we,
   input  logic [4:0]       reg_addr,
   input  logic [31:0]      reg_data,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic [CNT_W-1:0] drop_count
);

   trace_rec_t       rec_in_s, head_s;
   trace_rec_t       rec_q, rec_d;
   tx_state_e        state_q, state_d, nxt_state_s;
   logic [1:0]       idx_q, idx_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             fifo_full_s, fifo_empty_s, fifo_pop_s, fifo_push_s;
   logic             drop_s, hs_s;
   logic             gap_q, gap_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push_s),
      .pop_i   (fifo_pop_s),
      .wdata_i (rec_in_s),
      .rdata_o (head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign overflow    = overflow_q;
   assign drop_count  = drop_cnt_q;
   assign hs_s        = out_valid_q & out_ready;
   assign nxt_state_s = next_field(state_q, rec_q.is_nop, rec_q.mem_we, rec_q.reg_we);

   // Record assembly and accept/drop decision for the capture port.
   always_comb begin
      rec_in_s          = '0;
      rec_in_s.gap      = gap_q;
      rec_in_s.is_nop   = (instr == MIPS_NOP);
      rec_in_s.mem_we   = mem_we;
      rec_in_s.reg_we   = reg_we;
      rec_in_s.pc       = pc;
      rec_in_s.instr    = instr;
      rec_in_s.mem_addr = mem_addr;
      rec_in_s.mem_data = mem_data;
      rec_in_s.reg_addr = reg_addr;
      rec_in_s.reg_data = reg_data;
      fifo_push_s       = en & (~fifo_full_s | fifo_pop_s);
      drop_s            = en & fifo_full_s & ~fifo_pop_s;
   end

   // Gap flag, sticky overflow and saturating drop counter.
   always_comb begin
      gap_d      = gap_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (drop_s) begin
         gap_d      = 1'b1;
         overflow_d = 1'b1;
         if (drop_cnt_q != {CNT_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            drop_cnt_d = drop_cnt_q;
         end
      end else if (fifo_push_s) begin
         // The accepted record carried the gap flag into the FIFO.
         gap_d = 1'b0;
      end else begin
         gap_d = gap_q;
      end
   end

   // Drop bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_q      <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= {CNT_W{1'b0}};
      end else begin
         gap_q      <= gap_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Serializer FSM: state register plus registered stream outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         rec_q       <= '0;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rec_q       <= rec_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Serializer FSM: next state; pops the FIFO when a new packet starts.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rec_d      = rec_q;
      fifo_pop_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               fifo_pop_s = 1'b1;
               rec_d      = head_s;
               state_d    = ST_HDR;
               idx_d      = 2'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            if (hs_s) begin
               if (is_word_field(state_q) && (idx_q != 2'd3)) begin
                  idx_d = idx_q + 2'd1;
               end else begin
                  idx_d = 2'd0;
                  if (nxt_state_s != ST_IDLE) begin
                     state_d = nxt_state_s;
                  end else if (!fifo_empty_s) begin
                     // Back-to-back packet: next header follows immediately.
                     fifo_pop_s = 1'b1;
                     rec_d      = head_s;
                     state_d    = ST_HDR;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end else begin
               state_d = state_q;
            end
         end
      endcase
   end

   // Serializer FSM: output byte for the state being entered.
   always_comb begin
      out_valid_d = (state_d != ST_IDLE);
      if (state_d != ST_IDLE) begin
         out_data_d = field_byte(state_d, idx_d, rec_d);
      end else begin
         out_data_d = 8'h00;
      end
   end

endmodule
